mem_req_ctrl: RTL



---
 rtl/mem_req_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_req_ctrl.sv
// In-order request front-end for the mem block: command FIFO, issue FSM, held read response.
// Optional MEM_REQ_CTRL_STATS_EN adds saturating wr_cnt/rd_cnt outputs.
module mem_req_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr_rd,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_wr_rd,
    output logic [DATA_W-1:0]          mem_wr_data,
    input  logic [DATA_W-1:0]          mem_rd_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
`ifdef MEM_REQ_CTRL_STATS_EN
    output logic [15:0]                wr_cnt,
    output logic [15:0]                rd_cnt,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP_HOLD} state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    fifo_q [DEPTH];
    logic [ENT_W-1:0]    fifo_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wr_rd_q, mem_wr_rd_d;
    logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic [2:0]          lat_q, lat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                push, pop;
    logic [ENT_W-1:0]    head;
    logic                head_wr;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    assign req_ready   = (count_q < CNT_W'(DEPTH));
    assign push        = req_valid && req_ready;
    assign head        = fifo_q[rd_ptr_q];
    assign head_wr     = head[ENT_W-1];
    assign head_addr   = head[ENT_W-2 -: ADDR_W];
    assign head_data   = head[DATA_W-1:0];

    assign fifo_count  = count_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_rd   = mem_wr_rd_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_rd_d   = 1'b0;
        mem_wr_data_d = mem_wr_data_q;
        lat_d         = lat_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (|count_q) begin
                    pop        = 1'b1;
                    mem_addr_d = head_addr;
                    if (head_wr) begin
                        mem_wr_rd_d   = 1'b1;
                        mem_wr_data_d = head_data;
                    end else begin
                        lat_d   = 3'(RD_LAT);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q == 3'd0) begin
                    rsp_data_d  = mem_rd_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP_HOLD;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RSP_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {req_wr_rd, req_addr, req_wdata};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read when count_q says valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mem_addr_q    <= '0;
            mem_wr_rd_q   <= 1'b0;
            mem_wr_data_q <= '0;
            lat_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_rd_q   <= mem_wr_rd_d;
            mem_wr_data_q <= mem_wr_data_d;
            lat_q         <= lat_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (mem_wr_rd_d && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (state_q == RSP_HOLD && rsp_ready && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif

endmodule
